key_entry_buffer: RTL and testbench
===================================

// Module: key_entry_buffer
// PURPOSE
//  Consumes the 5-bit key code from the keypad scan driver. Debounces each press into a single
//  key event and assembles decimal digits into an N-digit entry register. Accepted entries are
//  presented to the display and control logic with a one-cycle strobe.
//  Sits directly downstream of the keypad driver, in the same 100 Hz clock domain.
// PARAMETERS
//  NUM_DIGITS    4   digits held in the entry register (BCD, 4 bits each)
//  DEBOUNCE_CYC  3   consecutive stable cycles required before a press is accepted (>=1)
//  RELEASE_CYC   3   consecutive released cycles required before re-arming (>=1)
// PORTS
//  clk          in   1             system clock (100 Hz). Single clock domain.
//  rst          in   1             synchronous, active-high reset
//  key_code     in   5             0..15 = key (0-9, A-D, E='*', F='#'); 16/17 = none/invalid
//  key_down     in   1             level, high while any keypad row reads active
//  key_stb      out  1             one-cycle pulse per accepted press
//  key_val      out  4             code of the last accepted key, held until the next press
//  digits       out  4*NUM_DIGITS  entry register; [3:0] is the most recent digit
//  digit_cnt    out  $clog2(NUM_DIGITS+1)  number of digits entered
//  entry_valid  out  1             one-cycle pulse when '#' commits an entry
//  entry_value  out  4*NUM_DIGITS  committed entry, held until the next commit
//  overflow     out  1             one-cycle pulse when a digit arrives with the register full
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, counters 0. Reset takes priority over every other event.
//  Sample rule: "pressed" means key_down=1 AND key_code<=15. Codes 16/17 count as released.
//  Debounce FSM:
//   IDLE     pressed -> DEBOUNCE; cand<=key_code; cnt<=1.
//   DEBOUNCE pressed and key_code==cand: cnt++.
//            When cnt reaches DEBOUNCE_CYC -> PRESSED; key_stb=1 on that cycle; key_val<=cand.
//            Released, or code differs from cand -> IDLE with cnt<=0. There is no strobe.
//   PRESSED  Holding the key produces no repeat. On release -> RELEASE with cnt<=1.
//   RELEASE  Released: cnt++. When cnt reaches RELEASE_CYC -> IDLE.
//            Pressed (any code) -> PRESSED. This is bounce on release and produces no event.
//  With DEBOUNCE_CYC=1, key_stb fires the cycle after the first pressed sample.
//  key_stb latency is DEBOUNCE_CYC cycles after the first pressed sample.
//  Entry actions happen on the same cycle as key_stb (registered, visible the next cycle):
//   0-9  digit_cnt<NUM_DIGITS: digits<={digits[4N-5:0],key}; digit_cnt++.
//        Otherwise the register is unchanged and overflow=1.
//   A    backspace: digits<=digits>>4; digit_cnt-- (no-op when 0).
//   C    clear: digits<=0; digit_cnt<=0.
//   F #  entry_value<=digits; entry_valid=1; digits<=0; digit_cnt<=0.
//        An empty commit is allowed and yields value 0.
//   B,D,E  key_stb/key_val update only. The entry register is unaffected.
//  digit_cnt never exceeds NUM_DIGITS and never goes negative.
//  Leading zeros count as digits.
//  Reset mid-debounce discards the candidate. A key still held after reset must pass a full
//  debounce from IDLE.
// STRUCTURE
//  Shared package/include: key code constants KEY_0..KEY_9, KEY_A..KEY_D, KEY_STAR=14, KEY_HASH=15,
//  KEY_NONE=16, KEY_INV=17; FSM state encodings.
//  Sub-module: key_debouncer (FSM plus counter; outputs key_stb/key_val).
//  The entry register and command decode stay in the top module.
// TESTING
//  1 Code 5 with key_down held 6 cycles, then released 5 -> exactly one key_stb, key_val=5,
//    digits[3:0]=5, digit_cnt=1.
//  2 Code 7 held 2 cycles, released, repeated 3 times (DEBOUNCE_CYC=3) -> no key_stb,
//    digits unchanged.
//  3 Press 1,2,3,4,9 with clean releases -> digits=16'h1234, cnt=4; one overflow pulse on 9.
//  4 Enter 1,2,3 then A then F -> digits 12 after A; entry_valid pulse, entry_value=16'h0012,
//    digits=0, cnt=0.
//  5 Hold 8 (accepted), released 1 cycle, re-pressed as 8 -> a single event, no second digit.
//  6 rst asserted during DEBOUNCE and during PRESSED -> all outputs 0 the next cycle;
//    a held key is accepted only after DEBOUNCE_CYC cycles post-reset.

Source files
------------

// File: rtl/key_entry_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_entry_buffer_pkg
//  Description : Key code constants, debouncer state encodings and the
//                "pressed" sample helper shared by the key entry buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package key_entry_buffer_pkg;

    // Keypad codes as delivered by the scan driver
    localparam logic [4:0] KEY_0    = 5'd0;
    localparam logic [4:0] KEY_1    = 5'd1;
    localparam logic [4:0] KEY_2    = 5'd2;
    localparam logic [4:0] KEY_3    = 5'd3;
    localparam logic [4:0] KEY_4    = 5'd4;
    localparam logic [4:0] KEY_5    = 5'd5;
    localparam logic [4:0] KEY_6    = 5'd6;
    localparam logic [4:0] KEY_7    = 5'd7;
    localparam logic [4:0] KEY_8    = 5'd8;
    localparam logic [4:0] KEY_9    = 5'd9;
    localparam logic [4:0] KEY_A    = 5'd10;
    localparam logic [4:0] KEY_B    = 5'd11;
    localparam logic [4:0] KEY_C    = 5'd12;
    localparam logic [4:0] KEY_D    = 5'd13;
    localparam logic [4:0] KEY_STAR = 5'd14;
    localparam logic [4:0] KEY_HASH = 5'd15;
    localparam logic [4:0] KEY_NONE = 5'd16;
    localparam logic [4:0] KEY_INV  = 5'd17;

    // Debouncer state encodings
    localparam int         c_ST_W        = 2;
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_ST_PRESSED  = 2'd2;
    localparam logic [1:0] c_ST_RELEASE  = 2'd3;

    // A sample counts as pressed only with a real key code; none/invalid
    // codes are treated exactly like a released keypad.
    function automatic logic is_pressed(input logic [4:0] code, input logic down);
        return down && (code <= KEY_HASH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : key_debouncer
//  Description : Turns the raw key_code/key_down level into one strobe per
//                press. A press must be stable for DEBOUNCE_CYC samples and
//                the keypad released for RELEASE_CYC samples before re-arming.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debouncer
    import key_entry_buffer_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 3,
    parameter int RELEASE_CYC  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key_code,
    input  logic       key_down,
    output logic       key_stb,
    output logic [3:0] key_val
);

    localparam int c_MAX_CNT = (DEBOUNCE_CYC > RELEASE_CYC) ? DEBOUNCE_CYC : RELEASE_CYC;
    localparam int c_CW      = $clog2(c_MAX_CNT + 1);
    localparam logic [c_CW-1:0] c_DEB_LAST = c_CW'(DEBOUNCE_CYC);
    localparam logic [c_CW-1:0] c_REL_LAST = c_CW'(RELEASE_CYC);
    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);

    logic [c_ST_W-1:0] r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [3:0]        r_cand;
    logic              r_stb;
    logic [3:0]        r_val;

    logic              w_pressed;
    logic              w_same;
    logic [c_CW-1:0]   w_cnt_inc;

    assign w_pressed = is_pressed(key_code, key_down);
    assign w_same    = (key_code[3:0] == r_cand);
    // The counter never passes c_MAX_CNT, so the increment cannot wrap.
    assign w_cnt_inc = r_cnt + c_ONE;

    // Debounce FSM: counts stable pressed / released samples and emits the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_stb   <= 1'b0;
            r_val   <= '0;
        end else begin
            r_stb <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pressed) begin
                        r_cand <= key_code[3:0];
                        // A single-sample debounce accepts on the first sample.
                        if (c_ONE >= c_DEB_LAST) begin
                            r_state <= c_ST_PRESSED;
                            r_stb   <= 1'b1;
                            r_val   <= key_code[3:0];
                            r_cnt   <= '0;
                        end else begin
                            r_state <= c_ST_DEBOUNCE;
                            r_cnt   <= c_ONE;
                        end
                    end
                end
                c_ST_DEBOUNCE: begin
                    if (w_pressed && w_same) begin
                        if (w_cnt_inc >= c_DEB_LAST) begin
                            r_state <= c_ST_PRESSED;
                            r_stb   <= 1'b1;
                            r_val   <= r_cand;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else begin
                        // Release or a different key abandons the candidate.
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                    end
                end
                c_ST_PRESSED: begin
                    // Holding the key never repeats; only release moves on.
                    if (!w_pressed) begin
                        if (c_ONE >= c_REL_LAST) begin
                            r_state <= c_ST_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= c_ST_RELEASE;
                            r_cnt   <= c_ONE;
                        end
                    end
                end
                c_ST_RELEASE: begin
                    if (w_pressed) begin
                        // Contact bounce while letting go: back to held, no event.
                        r_state <= c_ST_PRESSED;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc >= c_REL_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign key_stb = r_stb;
    assign key_val = r_val;

endmodule
`default_nettype wire

// File: rtl/key_entry_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : key_entry_buffer
//  Description : Debounced keypad front end plus a BCD entry register.
//                Digits shift in at the low nibble, A = backspace,
//                C = clear, # = commit. B, D and * only update key_val.
//  Revision    : 1.0  initial release
// ============================================================================
module key_entry_buffer
    import key_entry_buffer_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DEBOUNCE_CYC = 3,
    parameter int RELEASE_CYC  = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [4:0]                       key_code,
    input  logic                             key_down,
    output logic                             key_stb,
    output logic [3:0]                       key_val,
    output logic [4*NUM_DIGITS-1:0]          digits,
    output logic [$clog2(NUM_DIGITS+1)-1:0]  digit_cnt,
    output logic                             entry_valid,
    output logic [4*NUM_DIGITS-1:0]          entry_value,
    output logic                             overflow
);

    localparam int c_DW = 4 * NUM_DIGITS;
    localparam int c_CW = $clog2(NUM_DIGITS + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(NUM_DIGITS);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic             w_stb;
    logic [3:0]       w_val;
    logic             w_is_digit;

    logic [c_DW-1:0]  r_digits;
    logic [c_CW-1:0]  r_cnt;
    logic             r_entry_valid;
    logic [c_DW-1:0]  r_entry_value;
    logic             r_overflow;

    key_debouncer #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .RELEASE_CYC  (RELEASE_CYC)
    ) u_debouncer (
        .clk      (clk),
        .rst      (rst),
        .key_code (key_code),
        .key_down (key_down),
        .key_stb  (w_stb),
        .key_val  (w_val)
    );

    assign w_is_digit = ({1'b0, w_val} <= KEY_9);

    // Entry register: acts on each accepted key while its strobe is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits      <= '0;
            r_cnt         <= '0;
            r_entry_valid <= 1'b0;
            r_entry_value <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_entry_valid <= 1'b0;
            r_overflow    <= 1'b0;
            if (w_stb) begin
                if (w_is_digit) begin
                    if (r_cnt < c_FULL) begin
                        r_digits <= (r_digits << 4) | c_DW'(w_val);
                        r_cnt    <= r_cnt + c_ONE;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end else begin
                    case ({1'b0, w_val})
                        KEY_A: begin
                            if (r_cnt != '0) begin
                                r_digits <= r_digits >> 4;
                                r_cnt    <= r_cnt - c_ONE;
                            end
                        end
                        KEY_C: begin
                            r_digits <= '0;
                            r_cnt    <= '0;
                        end
                        KEY_HASH: begin
                            r_entry_value <= r_digits;
                            r_entry_valid <= 1'b1;
                            r_digits      <= '0;
                            r_cnt         <= '0;
                        end
                        default: begin
                            // B, D and * leave the entry register untouched.
                        end
                    endcase
                end
            end
        end
    end

    assign key_stb     = w_stb;
    assign key_val     = w_val;
    assign digits      = r_digits;
    assign digit_cnt   = r_cnt;
    assign entry_valid = r_entry_valid;
    assign entry_value = r_entry_value;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_entry_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_entry_buffer
//  Description : Self-checking bench for key_entry_buffer: directed keypad
//                scenarios plus random key streams against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_entry_buffer;

    localparam int N = 4;
    localparam int D = 3;
    localparam int R = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  key_code;
    logic        key_down;
    logic        key_stb;
    logic [3:0]  key_val;
    logic [15:0] digits;
    logic [2:0]  digit_cnt;
    logic        entry_valid;
    logic [15:0] entry_value;
    logic        overflow;

    key_entry_buffer #(
        .NUM_DIGITS   (N),
        .DEBOUNCE_CYC (D),
        .RELEASE_CYC  (R)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_code    (key_code),
        .key_down    (key_down),
        .key_stb     (key_stb),
        .key_val     (key_val),
        .digits      (digits),
        .digit_cnt   (digit_cnt),
        .entry_valid (entry_valid),
        .entry_value (entry_value),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // pulse counters observed by step()
    int cyc = 0;
    int c_stb, c_ovf, c_ev, first_stb;

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_CAND = 1, M_HELD = 2, M_LETGO = 3;
    int m_mode, m_cand, m_run, m_val, m_evalue;
    bit m_stb, m_ev, m_ovf;
    int q[$];   // entered digits, oldest first

    function automatic int qval();
        int v = 0;
        foreach (q[i]) v = v * 16 + q[i];
        return v;
    endfunction

    task automatic model_edge(input bit r, input int code, input bit down);
        bit p;
        p = down && (code <= 15);
        if (r) begin
            m_mode = M_IDLE; m_run = 0; m_cand = 0; m_stb = 0; m_val = 0;
            q.delete(); m_ev = 0; m_evalue = 0; m_ovf = 0;
            return;
        end
        m_ev = 0; m_ovf = 0;
        if (m_stb) begin
            if (m_val <= 9) begin
                if (q.size() < N) q.push_back(m_val); else m_ovf = 1;
            end else if (m_val == 10) begin
                if (q.size() > 0) void'(q.pop_back());
            end else if (m_val == 12) begin
                q.delete();
            end else if (m_val == 15) begin
                m_evalue = qval(); m_ev = 1; q.delete();
            end
        end
        m_stb = 0;
        case (m_mode)
            M_IDLE: if (p) begin
                m_cand = code; m_run = 1;
                if (m_run >= D) begin m_stb = 1; m_val = m_cand; m_mode = M_HELD; end
                else m_mode = M_CAND;
            end
            M_CAND: if (p && code == m_cand) begin
                m_run++;
                if (m_run >= D) begin m_stb = 1; m_val = m_cand; m_mode = M_HELD; end
            end else m_mode = M_IDLE;
            M_HELD: if (!p) begin
                m_run = 1;
                m_mode = (m_run >= R) ? M_IDLE : M_LETGO;
            end
            default: if (p) m_mode = M_HELD;
                     else begin m_run++; if (m_run >= R) m_mode = M_IDLE; end
        endcase
    endtask

    // ---------------- stimulus primitives ----------------
    task automatic step(input bit r, input int code, input bit down);
        rst = r; key_code = code[4:0]; key_down = down;
        @(posedge clk);
        model_edge(r, code, down);
        #1;
        cyc++;
        if (key_stb === 1'b1) begin
            c_stb++;
            if (first_stb < 0) first_stb = cyc;
        end
        if (overflow === 1'b1) c_ovf++;
        if (entry_valid === 1'b1) c_ev++;
    endtask

    task automatic clear_counts();
        c_stb = 0; c_ovf = 0; c_ev = 0; first_stb = -1;
    endtask

    task automatic do_reset();
        step(1, 16, 0);
        clear_counts();
    endtask

    task automatic press(input int k, input int hold, input int rel);
        for (int i = 0; i < hold; i++) step(0, k, 1);
        for (int i = 0; i < rel; i++) step(0, 16, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(1, 5, 1);
        step(1, 5, 1);
        clear_counts();
        n_cmp++;
        if ({key_stb, key_val, digits, digit_cnt, entry_valid, entry_value, overflow} !== 42'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {key_stb, key_val, digits, digit_cnt, entry_valid, entry_value, overflow});
        end
    endtask

    task automatic test_single_press();
        int start;
        do_reset();
        start = cyc;
        press(5, 6, 5);
        n_cmp++;
        if (c_stb !== 1) begin n_bad++; $display("FAIL single_stb_count: got %0d want 1", c_stb); end
        n_cmp++;
        if (first_stb - start !== D) begin
            n_bad++; $display("FAIL single_stb_latency: got %0d want %0d", first_stb - start, D);
        end
        n_cmp++;
        if (key_val !== 4'd5 || digits[3:0] !== 4'd5 || digit_cnt !== 3'd1) begin
            n_bad++;
            $display("FAIL single_entry: got val=%0d d=%h cnt=%0d want val=5 d[3:0]=5 cnt=1",
                     key_val, digits, digit_cnt);
        end
    endtask

    task automatic test_short_bounce();
        do_reset();
        for (int i = 0; i < 3; i++) press(7, 2, 2);
        n_cmp++;
        if (c_stb !== 0 || digits !== 16'h0 || digit_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL short_bounce: got stb=%0d d=%h cnt=%0d want 0/0/0", c_stb, digits, digit_cnt);
        end
    endtask

    task automatic test_overflow();
        int keys[5] = '{1, 2, 3, 4, 9};
        do_reset();
        foreach (keys[i]) press(keys[i], D + 1, R + 1);
        n_cmp++;
        if (digits !== 16'h1234 || digit_cnt !== 3'd4) begin
            n_bad++; $display("FAIL overflow_entry: got d=%h cnt=%0d want 1234/4", digits, digit_cnt);
        end
        n_cmp++;
        if (c_ovf !== 1) begin n_bad++; $display("FAIL overflow_pulses: got %0d want 1", c_ovf); end
    endtask

    task automatic test_backspace_commit();
        do_reset();
        press(1, 4, 4); press(2, 4, 4); press(3, 4, 4); press(10, 4, 4);
        n_cmp++;
        if (digits !== 16'h0012 || digit_cnt !== 3'd2) begin
            n_bad++; $display("FAIL backspace: got d=%h cnt=%0d want 0012/2", digits, digit_cnt);
        end
        clear_counts();
        press(15, 4, 4);
        n_cmp++;
        if (c_ev !== 1 || entry_value !== 16'h0012 || digits !== 16'h0 || digit_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL commit: got ev=%0d val=%h d=%h cnt=%0d want 1/0012/0/0",
                     c_ev, entry_value, digits, digit_cnt);
        end
        press(10, 4, 4);
        n_cmp++;
        if (digit_cnt !== 3'd0 || digits !== 16'h0) begin
            n_bad++; $display("FAIL backspace_empty: got d=%h cnt=%0d want 0/0", digits, digit_cnt);
        end
        clear_counts();
        press(15, 4, 4);
        n_cmp++;
        if (c_ev !== 1 || entry_value !== 16'h0) begin
            n_bad++; $display("FAIL empty_commit: got ev=%0d val=%h want 1/0000", c_ev, entry_value);
        end
        press(9, 4, 4); press(12, 4, 4);
        n_cmp++;
        if (digits !== 16'h0 || digit_cnt !== 3'd0 || key_val !== 4'hC) begin
            n_bad++; $display("FAIL clear: got d=%h cnt=%0d val=%h want 0/0/c", digits, digit_cnt, key_val);
        end
    endtask

    task automatic test_release_bounce();
        do_reset();
        press(8, 4, 1);
        press(8, 4, 4);
        n_cmp++;
        if (c_stb !== 1 || digits !== 16'h0008 || digit_cnt !== 3'd1) begin
            n_bad++;
            $display("FAIL release_bounce: got stb=%0d d=%h cnt=%0d want 1/0008/1", c_stb, digits, digit_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int at;
        do_reset();
        press(3, 4, 4);
        step(0, 6, 1); step(0, 6, 1);          // mid-debounce
        step(1, 6, 1);
        n_cmp++;
        if ({key_stb, key_val, digits, digit_cnt, entry_valid, entry_value, overflow} !== 42'd0) begin
            n_bad++;
            $display("FAIL reset_in_debounce: got %h want 0",
                     {key_stb, key_val, digits, digit_cnt, entry_valid, entry_value, overflow});
        end
        at = -1;
        for (int i = 1; i <= 6; i++) begin
            step(0, 6, 1);
            if (key_stb === 1'b1 && at < 0) at = i;
        end
        n_cmp++;
        if (at !== D) begin n_bad++; $display("FAIL post_reset_latency1: got %0d want %0d", at, D); end
        step(1, 6, 1);                          // reset while held
        n_cmp++;
        if ({key_stb, key_val, digits, digit_cnt, entry_valid, entry_value, overflow} !== 42'd0) begin
            n_bad++;
            $display("FAIL reset_in_pressed: got %h want 0",
                     {key_stb, key_val, digits, digit_cnt, entry_valid, entry_value, overflow});
        end
        at = -1;
        for (int i = 1; i <= 6; i++) begin
            step(0, 6, 1);
            if (key_stb === 1'b1 && at < 0) at = i;
        end
        n_cmp++;
        if (at !== D) begin n_bad++; $display("FAIL post_reset_latency2: got %0d want %0d", at, D); end
        press(6, 0, 4);
    endtask

    typedef struct { bit r; int code; bit down; } stim_t;

    task automatic test_random();
        stim_t s[$];
        int pick, k, hold, rel;
        logic [41:0] got, exp;
        for (int p = 0; p < 70; p++) begin
            pick = $urandom_range(0, 19);
            if (pick <= 9)       k = pick;
            else if (pick == 10) k = 10;
            else if (pick == 11) k = 12;
            else if (pick == 12) k = 15;
            else if (pick == 13) k = 11;
            else if (pick == 14) k = 13 + $urandom_range(0, 1);
            else if (pick == 15) k = 16 + $urandom_range(0, 1);
            else                 k = $urandom_range(0, 9);
            hold = $urandom_range(0, 6);
            rel  = $urandom_range(0, 5);
            for (int i = 0; i < hold; i++)
                s.push_back('{($urandom_range(0, 79) == 0),
                               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : k, 1'b1});
            for (int i = 0; i < rel; i++)
                s.push_back('{1'b0, 16 + $urandom_range(0, 1), 1'(($urandom_range(0, 3) == 0))});
        end
        foreach (s[i]) begin
            step(s[i].r, s[i].code, s[i].down);
            got = {key_stb, key_val, digits, digit_cnt, entry_valid, entry_value, overflow};
            exp = {m_stb, 4'(m_val), 16'(qval()), 3'(q.size()), m_ev, 16'(m_evalue), m_ovf};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL random_step %0d: got %h want %h", i, got, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; key_code = 5'd16; key_down = 1'b0;
        clear_counts();
        test_reset();
        test_single_press();
        test_short_bounce();
        test_overflow();
        test_backspace_commit();
        test_release_bounce();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
